ahb_bridge_arbiter: RTL and testbench
=====================================

# ahb_bridge_arbiter

Two-requester arbiter and transfer sequencer in front of the AHB-to-APB bridge. It selects one requester with round-robin priority and drives a single AHB NONSEQ transfer into the bridge's AHB slave port. It then waits for the bridge's ready-out and returns read data, response and a completion pulse to the granted requester. It is the only AHB master of the bridge; each requester sees a simple req/done handshake.

## Interface
Parameters:
- ADDR_W, 32, address width driven on HADDR.
- DATA_W, 32, data width of HWDATA/HRDATA.
- TIMEOUT_CYCLES, 64, data-phase wait limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  synchronous active-high reset.
- req0, req1  in  1 each  transfer request; must be held with its addr/wdata/write stable until the matching done.
- addr0, addr1  in  ADDR_W each  request address.
- wdata0, wdata1  in  DATA_W each  write data.
- write0, write1  in  1 each  1 = write, 0 = read.
- done0, done1  out  1 each  single-cycle completion pulse.
- err  out  1  valid with done; 1 = error response or timeout.
- rdata  out  DATA_W  read data; valid with done; holds until the next done.
- HADDR  out  ADDR_W  to bridge.
- HWDATA  out  DATA_W  to bridge.
- HWRITE  out  1  to bridge.
- HTRANS  out  2  to bridge; 2'b00 IDLE, 2'b10 NONSEQ.
- HREADY  out  1  to bridge; equals the registered copy of hready_out.
- hready_out  in  1  from bridge.
- hresp  in  2  from bridge; 2'b00 OKAY, any other value is an error.
- hrdata  in  DATA_W  from bridge.

## Operation
State machine states:
- IDLE: no transfer in progress; arbitrates among pending requests.
- ADDR: one-cycle address phase.
- DATA: waits for the bridge to complete the data phase.
- DONE: one-cycle completion, response and pointer update.

Arbitration (in IDLE only):
- Only one request pending: it wins.
- Both pending: the requester not equal to the `last` pointer wins.
- `last` resets to 1, so requester 0 wins the first tie.
- The winner is latched into `gnt`. Its addr, wdata and write are registered into HADDR, HWDATA and HWRITE.
- Move to ADDR.

ADDR:
- HTRANS = 2'b10.
- Always moves to DATA.

DATA:
- HTRANS = 2'b00.
- HADDR, HWDATA and HWRITE are held.
- When hready_out = 1: capture hrdata into rdata, set err = (hresp != 2'b00), move to DONE.

DONE:
- done[gnt] = 1 for this cycle only.
- `last` <= gnt.
- Move to IDLE. The next grant can occur in the following cycle.

Boundary and side rules:
- Only one transfer is ever outstanding.
- Requests arriving during ADDR, DATA or DONE wait for IDLE.
- A requester dropping req after its grant does not abort the transfer; done still pulses.
- rdata updates on writes as well; requesters ignore it for writes.

## Timing
Reset values (HRESET = 1 at a clock edge):
- State goes to IDLE.
- HTRANS = 2'b00.
- HADDR, HWDATA, rdata = 0.
- HWRITE, done0, done1, err = 0.
- HREADY = 1.
- `last` = 1.
- A transfer in flight is dropped; no done is issued.

Latency with req asserted at edge N:
- Grant at edge N+1.
- NONSEQ visible for cycle N+1..N+2.
- DATA from edge N+2.
- Zero-wait bridge (hready_out = 1 while in DATA): done at edge N+3.
- Each cycle of hready_out = 0 adds one cycle.
- Back-to-back transfers cost 4 cycles minimum.

Simultaneous events:
- Both req rising in the same cycle follows the tie rule above.
- A req held continuously after done is re-arbitrated in IDLE. When both requesters stay busy, grants alternate.

## Configuration
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit or wider counter clears on entry to DATA and increments each DATA cycle with hready_out = 0.
  - When it reaches TIMEOUT_CYCLES, the arbiter goes to DONE with err = 1 and rdata = 0. HTRANS stays IDLE.
- Undefined:
  - No counter is built.
  - DATA waits indefinitely for hready_out.

## Test plan
- Single read: reset, then req0 = 1, addr0 = 32'h0000_0010, write0 = 0, bridge returns hrdata = 32'hA5A5_0001 with hready_out = 1 -> HTRANS = 2'b10 exactly one cycle, done0 pulses 3 cycles after req, rdata = 32'hA5A5_0001, err = 0.
- Contention: req0 and req1 both held for 4 transfers -> grant order 0,1,0,1. done0 and done1 never overlap. Each transfer takes 4 cycles.
- Wait states and error: write from req1 with wdata1 = 32'h1234_5678, hready_out low for 3 DATA cycles, then high with hresp = 2'b01 -> HWDATA = 32'h1234_5678 stable throughout, done1 at 3 + 3 cycles, err = 1.
- Reset mid-transfer: assert HRESET during DATA -> next cycle HTRANS = 00, HREADY = 1, no done, `last` = 1. A tie afterwards grants requester 0.
- Request withdrawal: req0 deasserted the cycle after its grant -> transfer completes, done0 pulses once.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): hready_out held 0 -> done pulses after 8 DATA wait cycles, err = 1, rdata = 0, state returns to IDLE.

Source files
------------

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: two-requester round-robin arbiter issuing single AHB NONSEQ transfers into an AHB-to-APB bridge.
//
// Ports:
//   HCLK, HRESET            clock and synchronous active-high reset
//   req0/1, addr0/1,        requester handshakes; request fields held stable until done
//   wdata0/1, write0/1
//   done0/1                 single-cycle completion pulse to the granted requester
//   err, rdata              response and read data, valid with done, held until the next done
//   HADDR, HWDATA, HWRITE,  AHB master side driving the bridge's slave port
//   HTRANS, HREADY
//   hready_out, hresp,      bridge completion, response and read data
//   hrdata
//
// Optional feature: define ARB_TIMEOUT_EN to bound the data phase to TIMEOUT_CYCLES wait cycles.
module ahb_bridge_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              write0,
    input  logic              write1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic              HREADY,
    input  logic              hready_out,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              hwrite_q, hwrite_d;
    logic              err_q, err_d;
    logic              hready_q;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              any_req, pick, capture, complete, tmo;

    assign any_req  = req0 | req1;
    // On a tie the requester that was not served last wins.
    assign pick     = (req0 & req1) ? ~last_q : req1;
    assign capture  = (state_q == S_IDLE) && any_req;
    assign complete = (state_q == S_DATA) && hready_out;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign tmo = (state_q == S_DATA) && !hready_out && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = (state_q == S_ADDR) ? '0 :
                ((state_q == S_DATA) && !hready_out) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign tmo = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = S_DATA;
            S_DATA:  state_d = (hready_out || tmo) ? S_DONE : S_DATA;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = capture ? pick : gnt_q;
        haddr_d  = capture ? (pick ? addr1 : addr0) : haddr_q;
        hwdata_d = capture ? (pick ? wdata1 : wdata0) : hwdata_q;
        hwrite_d = capture ? (pick ? write1 : write0) : hwrite_q;
        rdata_d  = complete ? hrdata : tmo ? '0 : rdata_q;
        err_d    = complete ? (hresp != 2'b00) : tmo ? 1'b1 : err_q;
        last_d   = (state_q == S_DONE) ? gnt_q : last_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            hready_q <= 1'b1;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hwrite_q <= hwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            hready_q <= hready_out;
        end
    end

    always_comb begin
        HTRANS = (state_q == S_ADDR) ? 2'b10 : 2'b00;
        done0  = (state_q == S_DONE) && !gnt_q;
        done1  = (state_q == S_DONE) && gnt_q;
    end

    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign HWRITE = hwrite_q;
    assign HREADY = hready_q;
    assign rdata  = rdata_q;
    assign err    = err_q;
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter: directed and randomized transfers checked against a transaction-level model of the arbiter.
module tb_ahb_bridge_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req0, req1, write0, write1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err;
    logic [31:0] rdata, HADDR, HWDATA;
    logic        HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ahb_bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .write0(write0), .write1(write1),
        .done0(done0), .done1(done1), .err(err), .rdata(rdata),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HTRANS(HTRANS), .HREADY(HREADY),
        .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          last_m = 1;
    logic        rq[2];
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic        wr[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic drive();
        req0 = rq[0]; addr0 = a[0]; wdata0 = wd[0]; write0 = wr[0];
        req1 = rq[1]; addr1 = a[1]; wdata1 = wd[1]; write1 = wr[1];
    endtask

    // One complete transfer starting from IDLE; the winner and all timing come from the rules, not the DUT.
    task automatic xfer(input bit r0, input bit r1, input int waits, input logic [1:0] resp,
                        input bit drop, input bit hold, input bit rnd, input logic [31:0] rd);
        int w;
        int t0;
        for (int i = 0; i < 2; i++) begin
            if (rnd && !rq[i]) begin
                a[i]  = $urandom;
                wd[i] = $urandom;
                wr[i] = 1'($urandom_range(0, 1));
            end
        end
        rq[0] = r0;
        rq[1] = r1;
        drive();
        w = (r0 && r1) ? (last_m == 0 ? 1 : 0) : (r1 ? 1 : 0);
        hready_out = 1'b0;
        t0 = cyc;
        step();
        chk("htrans_nonseq", HTRANS, 2'b10);
        chk("haddr", HADDR, a[w]);
        chk("hwdata", HWDATA, wd[w]);
        chk("hwrite", HWRITE, wr[w]);
        chk("no_done_addr", {done1, done0}, 2'b00);
        if (drop) begin
            rq[w] = 1'b0;
            drive();
        end
        step();
        chk("htrans_data", HTRANS, 2'b00);
        chk("hready_copy", HREADY, 1'b0);
        for (int k = 0; k <= waits; k++) begin
            hready_out = (k == waits);
            hresp = (k == waits) ? resp : 2'($urandom);
            hrdata = (k == waits) ? rd : $urandom;
            step();
            chk("hready_copy", HREADY, (k == waits));
            chk("haddr_hold", HADDR, a[w]);
            chk("hwdata_hold", HWDATA, wd[w]);
            if (k < waits) begin
                chk("htrans_wait", HTRANS, 2'b00);
                chk("no_done_wait", {done1, done0}, 2'b00);
            end
        end
        chk("done", {done1, done0}, w ? 2'b10 : 2'b01);
        chk("latency", 64'(cyc - t0), 64'(3 + waits));
        chk("rdata", rdata, rd);
        chk("err", err, resp != 2'b00);
        last_m = w;
        if (!hold) begin
            rq[0] = 1'b0;
            rq[1] = 1'b0;
        end
        drive();
        hready_out = 1'b0;
        step();
        chk("single_pulse", {done1, done0}, 2'b00);
        chk("htrans_idle", HTRANS, 2'b00);
        chk("rdata_hold", rdata, rd);
    endtask

    initial begin
        HRESET = 1'b1;
        hready_out = 1'b0;
        hresp = 2'b00;
        hrdata = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; a[i] = '0; wd[i] = '0; wr[i] = 1'b0;
        end
        drive();
        @(negedge HCLK);
        step();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hready", HREADY, 1'b1);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_done", {done1, done0}, 2'b00);
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_htrans", HTRANS, 2'b00);
            chk("idle_done", {done1, done0}, 2'b00);
        end

        // Contention: both held for four transfers, grants alternate from requester 0.
        for (int i = 0; i < 4; i++) xfer(1, 1, 0, 2'b00, 0, i < 3, 1, $urandom);

        // Single read with fixed values.
        a[0] = 32'h0000_0010; wd[0] = 32'h0; wr[0] = 1'b0;
        xfer(1, 0, 0, 2'b00, 0, 0, 0, 32'hA5A5_0001);

        // Write from requester 1 with three wait states and an error response.
        a[1] = 32'h0000_0200; wd[1] = 32'h1234_5678; wr[1] = 1'b1;
        xfer(0, 1, 3, 2'b01, 0, 0, 0, 32'hDEAD_BEEF);

        // Requester withdraws after grant.
        xfer(1, 0, 1, 2'b00, 1, 0, 1, $urandom);

        // Reset during DATA: transfer dropped, pointer restored so requester 0 wins the next tie.
        rq[1] = 1'b1; a[1] = $urandom; wd[1] = $urandom; wr[1] = 1'b0;
        drive();
        step();
        step();
        chk("pre_rst_data", HTRANS, 2'b00);
        HRESET = 1'b1;
        step();
        chk("mid_rst_htrans", HTRANS, 2'b00);
        chk("mid_rst_hready", HREADY, 1'b1);
        chk("mid_rst_done", {done1, done0}, 2'b00);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_haddr", HADDR, 32'h0);
        HRESET = 1'b0;
        rq[1] = 1'b0;
        drive();
        hready_out = 1'b1;
        step();
        chk("post_rst_done", {done1, done0}, 2'b00);
        chk("post_rst_htrans", HTRANS, 2'b00);
        hready_out = 1'b0;
        last_m = 1;
        xfer(1, 1, 0, 2'b00, 0, 0, 1, $urandom);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            int p;
            p = $urandom_range(1, 3);
            xfer(p[0], p[1], $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, 0, 1, $urandom);
        end

`ifdef ARB_TIMEOUT_EN
        // Bridge never ready: done after TO wait cycles with an error and zeroed data.
        rq[0] = 1'b1; a[0] = $urandom; wd[0] = $urandom; wr[0] = 1'b0;
        drive();
        hready_out = 1'b0;
        step();
        rq[0] = 1'b0;
        drive();
        step();
        for (int k = 0; k < TO - 1; k++) begin
            step();
            chk("tmo_wait", {done1, done0}, 2'b00);
        end
        step();
        chk("tmo_done", {done1, done0}, 2'b01);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata", rdata, 32'h0);
        chk("tmo_htrans", HTRANS, 2'b00);
        step();
        chk("tmo_idle", {done1, done0}, 2'b00);
        last_m = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
